// File: rtl/input_cond_pkg.sv
// Shared definitions for the two-channel input conditioner.
// State encoding, default debounce length and a settled-state helper.
package input_cond_pkg;

  typedef logic [1:0] state_t;

  localparam state_t LOW      = 2'd0;
  localparam state_t RISE_CHK = 2'd1;
  localparam state_t HIGH     = 2'd2;
  localparam state_t FALL_CHK = 2'd3;

  localparam int DEF_DEBOUNCE_CYCLES = 4;

  function automatic logic is_settled(input state_t s);
    return (s == LOW) || (s == HIGH);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-flop synchroniser, debounce FSM with
// saturating counter, registered level and one-cycle edge pulses.
module debounce_channel
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 16
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   raw,
  output logic   level,
  output logic   rise,
  output logic   fall,
  output state_t state
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Compare before increment, so the counter never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOW;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      unique case (state)
        LOW: begin
          if (s2) begin
            state <= RISE_CHK;
            cnt   <= '0;
          end
        end
        RISE_CHK: begin
          if (!s2) begin
            state <= LOW;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= HIGH;
            level <= 1'b1;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (!s2) begin
            state <= FALL_CHK;
            cnt   <= '0;
          end
        end
        FALL_CHK: begin
          if (s2) begin
            state <= HIGH;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= LOW;
            level <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/logic_input_conditioner.sv
// Conditions two raw inputs into debounced levels a/b for the
// logic block, with edge pulses and a combined stable flag.
module logic_input_conditioner
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall,
  output logic stable
);

  state_t a_state;
  state_t b_state;

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_a (
    .clk  (clk),
    .reset(reset),
    .raw  (a_raw),
    .level(a),
    .rise (a_rise),
    .fall (a_fall),
    .state(a_state)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_b (
    .clk  (clk),
    .reset(reset),
    .raw  (b_raw),
    .level(b),
    .rise (b_rise),
    .fall (b_fall),
    .state(b_state)
  );

  // Registered from current FSM states: drops the cycle after a check begins.
  always_ff @(posedge clk) begin
    if (reset) stable <= 1'b1;
    else       stable <= is_settled(a_state) && is_settled(b_state);
  end

endmodule
